axis_hdr_insert_sched: RTL and testbench
========================================

# axis_hdr_insert_sched

Round-robin scheduler that shares one `axi_stream_insert_header` datapath between N_CH requesters, each owning a header source and a payload stream. It grants one channel at a time, forwards that channel's header to the inserter's insert port, then routes that channel's payload beats to the inserter's data input. It holds the grant until the inserter's output shows the packet's last beat, then re-arbitrates. It sits directly in front of the inserter; the inserter's output stream is only monitored, not driven.

## Interface
- N_CH, 4, number of requesters (2..16)
- DATA_WD, 32, data width in bits
- DATA_BYTE_WD, DATA_WD/8, bytes per beat
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD), header byte-count width
- CH_WD, max(1,$clog2(N_CH)), channel index width

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- s_hdr_valid  in  N_CH  per-channel header valid
- s_hdr_data  in  N_CH*DATA_WD  headers, channel i at [i*DATA_WD +: DATA_WD]
- s_hdr_keep  in  N_CH*DATA_BYTE_WD  header keep, packed likewise
- s_hdr_byte_cnt  in  N_CH*BYTE_CNT_WD  header byte count, packed likewise
- s_hdr_ready  out  N_CH  per-channel header ready
- s_pay_valid / s_pay_last  in  N_CH  per-channel payload valid / last
- s_pay_data / s_pay_keep  in  N_CH*DATA_WD / N_CH*DATA_BYTE_WD  payload, packed
- s_pay_ready  out  N_CH  per-channel payload ready
- m_ins_valid, m_ins_data, m_ins_keep, m_ins_byte_cnt  out  1/DATA_WD/DATA_BYTE_WD/BYTE_CNT_WD  to inserter valid_insert/data_insert/keep_insert/byte_insert_cnt
- m_ins_ready  in  1  from inserter ready_insert
- m_pay_valid, m_pay_data, m_pay_keep, m_pay_last  out  1/DATA_WD/DATA_BYTE_WD/1  to inserter valid_in/data_in/keep_in/last_in
- m_pay_ready  in  1  from inserter ready_in
- mon_valid, mon_ready, mon_last  in  1 each  tap of inserter valid_out/ready_out/last_out
- grant_id  out  CH_WD  current or last granted channel
- busy  out  1  high in every state except IDLE
- err_stray  out  1  one-cycle pulse on a mon last handshake outside PAY/DRAIN

## Operation
- FSM states: IDLE, HDR, PAY, DRAIN.
- IDLE: if any s_hdr_valid is set, the arbiter picks the first requesting channel, searching from ptr+1 upward with wrap. It registers grant_id, sets ptr to that channel, and moves to HDR. No s_*_ready asserted.
- HDR: m_ins_* is combinationally muxed from the granted channel. s_hdr_ready[g]=m_ins_ready; all other readys are 0. On m_ins_valid&&m_ins_ready, go to PAY.
- PAY: m_pay_* is muxed from the granted channel. s_pay_ready[g]=m_pay_ready; others 0. m_ins_valid=0. On handshake with m_pay_last: go to DRAIN, or go to IDLE if done_seen is set.
- DRAIN: all readys 0. On mon_valid&&mon_ready&&mon_last, go to IDLE.
- done_seen: set by a mon last handshake in PAY; cleared on entry to IDLE.
- A mon last handshake in IDLE or HDR pulses err_stray. The FSM is unaffected.
- Non-granted channels are never acknowledged. Their valid/data must be held by the source (AXI-Stream rules).
- Reset (any state, asynchronous): state=IDLE, ptr=N_CH-1 (channel 0 wins first), grant_id=0, done_seen=0, busy=0, err_stray=0. All s_*_ready=0, m_ins_valid=0, m_pay_valid=0. Muxed data outputs are 0 in IDLE. An in-flight packet is abandoned.

## Timing
- Arbitration latency: first s_hdr_valid cycle in IDLE → m_ins_valid high the next cycle.
- The HDR and PAY datapaths are zero-latency combinational passthrough. No valid depends on its own ready.
- Minimum inter-packet gap: one IDLE cycle.
- A channel whose s_hdr_valid drops while in IDLE before being granted is simply not granted (no retention).

## Structure
- Shared package axis_hdr_pkg holds: the state enum (IDLE=0, HDR=1, PAY=2, DRAIN=3) and the CH_WD helper function.
- One sub-module, axis_rr_arbiter:
  - parameter N_CH
  - inputs req[N_CH], ptr
  - outputs any, gnt_idx
  - purely combinational priority rotate
- FSM, muxes, ptr and done_seen live in the top module.

## Test plan
- Single channel 2: header 0xAABBCCDD, byte_cnt 1; payload 3 beats, last keep 4'b1100 → grant_id=2; m_ins handshake one cycle after hdr_valid; 3 beats forwarded; IDLE after mon last.
- All 4 channels request continuously, 1-beat packets → grants in order 0,1,2,3,0; each grant separated by ≥1 IDLE cycle.
- m_ins_ready held low 5 cycles in HDR → state stays HDR; s_hdr_ready[g]=0; no payload readiness; proceeds on the 6th.
- Channel 1 payload valid while channel 0 granted → s_pay_ready[1]=0 throughout; channel 1 data never appears on m_pay_data.
- mon last handshake while IDLE → err_stray one-cycle pulse, state IDLE. Mon last during PAY → IDLE directly after m_pay_last handshake, no DRAIN.
- rst_n asserted mid-PAY → outputs zero immediately (asynchronously). After release, channel 0 wins if channels 0 and 3 both request.

Source files
------------

// File: rtl/axis_hdr_pkg.sv
// Shared types and helpers for the header-insert scheduler.
package axis_hdr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HDR   = 2'd1,
    PAY   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  function automatic int unsigned ch_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after ptr, with wrap.
module axis_rr_arbiter
  import axis_hdr_pkg::*;
#(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned CH_WD = ch_width(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [CH_WD-1:0] ptr,
  output logic             any,
  output logic [CH_WD-1:0] gnt_idx
);

  int unsigned       idx;
  logic [N_CH-1:0]   rot;

  always_comb begin
    any     = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    rot     = '0;
    for (int unsigned k = 1; k <= N_CH; k++) begin
      idx = (32'(ptr) + k) % N_CH;
      rot = req >> idx;
      if (!any && rot[0]) begin
        any     = 1'b1;
        gnt_idx = CH_WD'(idx);
      end
    end
  end

endmodule

// File: rtl/axis_hdr_insert_sched.sv
// Round-robin scheduler sharing one header inserter among N_CH header/payload
// requesters; holds the grant until the inserter output shows the packet's last beat.
module axis_hdr_insert_sched
  import axis_hdr_pkg::*;
#(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned DATA_WD      = 32,
  parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
  parameter int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
  parameter int unsigned CH_WD        = ch_width(N_CH)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_CH-1:0]               s_hdr_valid,
  input  logic [N_CH*DATA_WD-1:0]       s_hdr_data,
  input  logic [N_CH*DATA_BYTE_WD-1:0]  s_hdr_keep,
  input  logic [N_CH*BYTE_CNT_WD-1:0]   s_hdr_byte_cnt,
  output logic [N_CH-1:0]               s_hdr_ready,
  input  logic [N_CH-1:0]               s_pay_valid,
  input  logic [N_CH-1:0]               s_pay_last,
  input  logic [N_CH*DATA_WD-1:0]       s_pay_data,
  input  logic [N_CH*DATA_BYTE_WD-1:0]  s_pay_keep,
  output logic [N_CH-1:0]               s_pay_ready,
  output logic                          m_ins_valid,
  output logic [DATA_WD-1:0]            m_ins_data,
  output logic [DATA_BYTE_WD-1:0]       m_ins_keep,
  output logic [BYTE_CNT_WD-1:0]        m_ins_byte_cnt,
  input  logic                          m_ins_ready,
  output logic                          m_pay_valid,
  output logic [DATA_WD-1:0]            m_pay_data,
  output logic [DATA_BYTE_WD-1:0]       m_pay_keep,
  output logic                          m_pay_last,
  input  logic                          m_pay_ready,
  input  logic                          mon_valid,
  input  logic                          mon_ready,
  input  logic                          mon_last,
  output logic [CH_WD-1:0]              grant_id,
  output logic                          busy,
  output logic                          err_stray
);

  state_t           state, state_nxt;
  logic [CH_WD-1:0] ptr;
  logic             done_seen;
  logic             arb_any;
  logic [CH_WD-1:0] arb_idx;
  logic             mon_last_hs;

  assign mon_last_hs = mon_valid & mon_ready & mon_last;
  assign busy        = (state != IDLE);

  axis_rr_arbiter #(
    .N_CH  (N_CH),
    .CH_WD (CH_WD)
  ) u_arb (
    .req     (s_hdr_valid),
    .ptr     (ptr),
    .any     (arb_any),
    .gnt_idx (arb_idx)
  );

  always_comb begin
    state_nxt      = state;
    s_hdr_ready    = '0;
    s_pay_ready    = '0;
    m_ins_valid    = 1'b0;
    m_ins_data     = '0;
    m_ins_keep     = '0;
    m_ins_byte_cnt = '0;
    m_pay_valid    = 1'b0;
    m_pay_data     = '0;
    m_pay_keep     = '0;
    m_pay_last     = 1'b0;
    unique case (state)
      IDLE: begin
        if (arb_any) state_nxt = HDR;
      end
      HDR: begin
        m_ins_valid           = s_hdr_valid[grant_id];
        m_ins_data            = s_hdr_data[grant_id*DATA_WD +: DATA_WD];
        m_ins_keep            = s_hdr_keep[grant_id*DATA_BYTE_WD +: DATA_BYTE_WD];
        m_ins_byte_cnt        = s_hdr_byte_cnt[grant_id*BYTE_CNT_WD +: BYTE_CNT_WD];
        s_hdr_ready[grant_id] = m_ins_ready;
        if (m_ins_valid && m_ins_ready) state_nxt = PAY;
      end
      PAY: begin
        m_pay_valid           = s_pay_valid[grant_id];
        m_pay_data            = s_pay_data[grant_id*DATA_WD +: DATA_WD];
        m_pay_keep            = s_pay_keep[grant_id*DATA_BYTE_WD +: DATA_BYTE_WD];
        m_pay_last            = s_pay_last[grant_id];
        s_pay_ready[grant_id] = m_pay_ready;
        // An output last seen in the same cycle counts as already done, else DRAIN would wait forever.
        if (m_pay_valid && m_pay_ready && m_pay_last)
          state_nxt = (done_seen || mon_last_hs) ? IDLE : DRAIN;
      end
      DRAIN: begin
        if (mon_last_hs) state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= CH_WD'(N_CH - 1);
      grant_id  <= '0;
      done_seen <= 1'b0;
      err_stray <= 1'b0;
    end else begin
      state     <= state_nxt;
      err_stray <= mon_last_hs && (state == IDLE || state == HDR);
      if (state == IDLE && arb_any) begin
        grant_id <= arb_idx;
        ptr      <= arb_idx;
      end
      if (state_nxt == IDLE)
        done_seen <= 1'b0;
      else if (state == PAY && mon_last_hs)
        done_seen <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_hdr_insert_sched.sv
// Randomized bench for axis_hdr_insert_sched: per-channel packet sources, scoreboard
// queues filled at packet creation, and a packet-lifecycle reference model in the monitor.
module tb_axis_hdr_insert_sched;
  localparam int unsigned N  = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;
  localparam int unsigned CW = 2;
  localparam int unsigned GW = 2;

  typedef struct packed {
    logic [DW-1:0]         hdr;
    logic [BW-1:0]         hkeep;
    logic [CW-1:0]         hcnt;
    logic [2:0]            nb;
    logic [3:0][DW-1:0]    d;
    logic [3:0][BW-1:0]    k;
  } pkt_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0]    s_hdr_valid = '0, s_hdr_ready;
  logic [N*DW-1:0] s_hdr_data = '0;
  logic [N*BW-1:0] s_hdr_keep = '0;
  logic [N*CW-1:0] s_hdr_byte_cnt = '0;
  logic [N-1:0]    s_pay_valid = '0, s_pay_last = '0, s_pay_ready;
  logic [N*DW-1:0] s_pay_data = '0;
  logic [N*BW-1:0] s_pay_keep = '0;
  logic            m_ins_valid, m_ins_ready = 1'b0;
  logic [DW-1:0]   m_ins_data;
  logic [BW-1:0]   m_ins_keep;
  logic [CW-1:0]   m_ins_byte_cnt;
  logic            m_pay_valid, m_pay_last, m_pay_ready = 1'b0;
  logic [DW-1:0]   m_pay_data;
  logic [BW-1:0]   m_pay_keep;
  logic            mon_valid = 1'b0, mon_ready = 1'b0, mon_last = 1'b0;
  logic [GW-1:0]   grant_id;
  logic            busy, err_stray;

  always #5 clk = ~clk;

  axis_hdr_insert_sched #(.N_CH(N), .DATA_WD(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_hdr_valid(s_hdr_valid), .s_hdr_data(s_hdr_data), .s_hdr_keep(s_hdr_keep),
    .s_hdr_byte_cnt(s_hdr_byte_cnt), .s_hdr_ready(s_hdr_ready),
    .s_pay_valid(s_pay_valid), .s_pay_last(s_pay_last), .s_pay_data(s_pay_data),
    .s_pay_keep(s_pay_keep), .s_pay_ready(s_pay_ready),
    .m_ins_valid(m_ins_valid), .m_ins_data(m_ins_data), .m_ins_keep(m_ins_keep),
    .m_ins_byte_cnt(m_ins_byte_cnt), .m_ins_ready(m_ins_ready),
    .m_pay_valid(m_pay_valid), .m_pay_data(m_pay_data), .m_pay_keep(m_pay_keep),
    .m_pay_last(m_pay_last), .m_pay_ready(m_pay_ready),
    .mon_valid(mon_valid), .mon_ready(mon_ready), .mon_last(mon_last),
    .grant_id(grant_id), .busy(busy), .err_stray(err_stray)
  );

  int   total = 0;
  int   bad   = 0;
  pkt_t exp_q [N][$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Round-robin rule: first requester after the last grant, with wrap.
  function automatic int rr(input logic [N-1:0] v, input int last);
    logic [N-1:0] s;
    for (int k = 1; k <= N; k++) begin
      s = v >> ((last + k) % N);
      if (s[0]) return (last + k) % N;
    end
    return 0;
  endfunction

  // ---------------- monitor / reference model ----------------
  int          ph, mg, lastg;
  int unsigned beat;
  bit          done_pkt, exp_stray;
  pkt_t        cur;
  logic        mhs;
  logic [N-1:0] one_g;

  always @(negedge clk) begin
    if (!rst_n) begin
      ph = 0; mg = 0; lastg = N - 1; beat = 0; done_pkt = 0; exp_stray = 0;
      for (int c = 0; c < N; c++) exp_q[c].delete();
    end else begin
      mhs   = mon_valid & mon_ready & mon_last;
      one_g = N'(1) << mg;
      chk("busy", busy, ph != 0);
      chk("err_stray", err_stray, exp_stray);
      exp_stray = mhs && (ph == 0 || ph == 1);
      chk("ins_valid", m_ins_valid, ph == 1);
      chk("hdr_ready", s_hdr_ready, (ph == 1 && m_ins_ready) ? one_g : '0);
      chk("pay_valid", m_pay_valid, ph == 2 && s_pay_valid[mg]);
      chk("pay_ready", s_pay_ready, (ph == 2 && m_pay_ready) ? one_g : '0);
      if (ph != 0) chk("grant_id", grant_id, mg);
      case (ph)
        0: if (s_hdr_valid != '0) begin
             mg = rr(s_hdr_valid, lastg); lastg = mg; done_pkt = 0; ph = 1;
           end
        1: begin
             chk("hdr_queue_nonempty", exp_q[mg].size() != 0, 1);
             if (exp_q[mg].size() != 0) begin
               chk("ins_data", m_ins_data, exp_q[mg][0].hdr);
               chk("ins_keep", m_ins_keep, exp_q[mg][0].hkeep);
               chk("ins_cnt", m_ins_byte_cnt, exp_q[mg][0].hcnt);
               if (m_ins_ready) begin cur = exp_q[mg].pop_front(); beat = 0; ph = 2; end
             end
           end
        2: begin
             if (mhs) done_pkt = 1;
             if (s_pay_valid[mg] && m_pay_ready) begin
               chk("pay_data", m_pay_data, cur.d[beat[1:0]]);
               chk("pay_keep", m_pay_keep, cur.k[beat[1:0]]);
               chk("pay_last", m_pay_last, beat == 32'(cur.nb) - 1);
               beat++;
               if (beat == 32'(cur.nb)) ph = done_pkt ? 0 : 3;
             end
           end
        default: if (mhs) ph = 0;
      endcase
    end
  end

  // ---------------- sources and inserter-side stimulus ----------------
  bit          act [N];
  int unsigned bt [N];
  int unsigned gap [N];
  pkt_t        dc [N];
  bit          gen_en = 0, one_beat = 0, cont = 0, early_en = 0, stall_mode = 0, force_mon = 0;
  bit          early = 0;
  int          mon_cnt = -1;
  int          ins_wait = 0;
  logic [N-1:0] cap_hh, cap_ph;
  logic        cap_ins, cap_last;

  function automatic pkt_t new_pkt(input bit one);
    pkt_t p;
    p.hdr   = $urandom;
    p.hkeep = BW'($urandom);
    p.hcnt  = CW'($urandom);
    p.nb    = one ? 3'd1 : 3'(1 + $urandom % 4);
    for (int i = 0; i < 4; i++) begin
      p.d[i] = $urandom;
      p.k[i] = (i == int'(p.nb) - 1) ? BW'($urandom_range(1, 15)) : '1;
    end
    return p;
  endfunction

  task automatic drive_ch(input int c);
    s_hdr_data[c*DW +: DW]     = s_hdr_valid[c] ? dc[c].hdr   : DW'($urandom);
    s_hdr_keep[c*BW +: BW]     = s_hdr_valid[c] ? dc[c].hkeep : BW'($urandom);
    s_hdr_byte_cnt[c*CW +: CW] = s_hdr_valid[c] ? dc[c].hcnt  : CW'($urandom);
    if (s_pay_valid[c]) begin
      s_pay_data[c*DW +: DW] = dc[c].d[bt[c][1:0]];
      s_pay_keep[c*BW +: BW] = dc[c].k[bt[c][1:0]];
      s_pay_last[c]          = (bt[c] == 32'(dc[c].nb) - 1);
    end else begin
      s_pay_data[c*DW +: DW] = DW'($urandom);
      s_pay_keep[c*BW +: BW] = BW'($urandom);
      s_pay_last[c]          = 1'($urandom);
    end
  endtask

  task automatic start_pkt(input int c, input pkt_t p);
    dc[c] = p; act[c] = 1; bt[c] = 0;
    exp_q[c].push_back(p);
    s_hdr_valid[c] = 1'b1;
    s_pay_valid[c] = 1'b1;
    drive_ch(c);
  endtask

  task automatic step();
    @(negedge clk);
    cap_hh   = s_hdr_valid & s_hdr_ready;
    cap_ph   = s_pay_valid & s_pay_ready;
    cap_ins  = m_ins_valid & m_ins_ready;
    cap_last = m_pay_valid & m_pay_ready & m_pay_last;
    @(posedge clk); #1;
    if (m_ins_valid) ins_wait++; else ins_wait = 0;
    m_ins_ready = stall_mode ? (ins_wait > 5) : ($urandom % 4 != 0);
    m_pay_ready = ($urandom % 4 != 0);
    if (cap_ins) begin
      early = early_en && ($urandom % 3 == 0);
      if (early) mon_cnt = 0;
    end
    if (cap_last) begin
      if (!early) mon_cnt = int'($urandom % 3);
      early = 0;
    end
    if (force_mon || mon_cnt == 0) begin
      mon_valid = 1; mon_ready = 1; mon_last = 1;
      if (mon_cnt == 0) mon_cnt = -1;
    end else begin
      if (mon_cnt > 0) mon_cnt--;
      mon_valid = 1'($urandom); mon_ready = 0; mon_last = 1'($urandom);
    end
    for (int c = 0; c < N; c++) begin
      if (act[c]) begin
        if (cap_hh[c]) s_hdr_valid[c] = 1'b0;
        if (cap_ph[c]) begin
          bt[c]++;
          if (bt[c] == 32'(dc[c].nb)) begin
            act[c] = 0; s_pay_valid[c] = 1'b0; gap[c] = cont ? 0 : $urandom % 3;
          end else s_pay_valid[c] = ($urandom % 4 != 0);
        end else if (!s_pay_valid[c]) s_pay_valid[c] = 1'b1;
      end else if (gap[c] != 0) gap[c]--;
      else if (gen_en && (cont || $urandom % 2 == 0)) start_pkt(c, new_pkt(one_beat));
      drive_ch(c);
    end
  endtask

  task automatic drain();
    bit pend;
    gen_en = 0; cont = 0;
    pend = 1;
    for (int i = 0; i < 500 && pend; i++) begin
      step();
      pend = busy || mon_cnt >= 0;
      for (int c = 0; c < N; c++) pend = pend || act[c];
    end
    chk("drain_done", pend, 0);
  endtask

  task automatic clear_src();
    for (int c = 0; c < N; c++) begin act[c] = 0; bt[c] = 0; gap[c] = 0; end
    s_hdr_valid = '0; s_pay_valid = '0;
    mon_cnt = -1; early = 0; ins_wait = 0;
    mon_valid = 0; mon_ready = 0; mon_last = 0;
  endtask

  pkt_t tp;

  initial begin
    clear_src();
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_hdr_ready", s_hdr_ready, 0);
    chk("rst_pay_ready", s_pay_ready, 0);
    chk("rst_ins_valid", m_ins_valid, 0);
    chk("rst_pay_valid", m_pay_valid, 0);
    chk("rst_err_stray", err_stray, 0);
    chk("rst_ins_data", m_ins_data, 0);
    @(posedge clk); #1 rst_n = 1;

    // Fixed packet on channel 2.
    tp = new_pkt(0);
    tp.hdr = 32'hAABBCCDD; tp.hcnt = 2'd1; tp.nb = 3'd3; tp.k[2] = 4'b1100;
    start_pkt(2, tp);
    step();
    chk("ch2_grant", grant_id, 2);
    drain();

    // Header port stalled for five cycles.
    stall_mode = 1;
    start_pkt(1, new_pkt(0));
    drain();
    stall_mode = 0;

    // All channels continuously requesting single-beat packets.
    one_beat = 1; cont = 1; gen_en = 1;
    repeat (80) step();
    drain();
    one_beat = 0;

    // Random traffic, including output-last seen during PAY.
    early_en = 1; gen_en = 1;
    repeat (1500) step();
    drain();
    early_en = 0;

    // Stray output-last while idle.
    force_mon = 1; step(); force_mon = 0;
    repeat (3) step();

    // Asynchronous reset in the middle of a payload.
    tp = new_pkt(0); tp.nb = 3'd3;
    start_pkt(2, tp);
    for (int i = 0; i < 60 && bt[2] == 0; i++) step();
    chk("reached_pay", bt[2] != 0, 1);
    #1 rst_n = 0;
    #1;
    chk("arst_pay_ready", s_pay_ready, 0);
    chk("arst_pay_valid", m_pay_valid, 0);
    chk("arst_pay_data", m_pay_data, 0);
    chk("arst_busy", busy, 0);
    chk("arst_grant", grant_id, 0);
    clear_src();
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1;
    start_pkt(3, new_pkt(0));
    start_pkt(0, new_pkt(0));
    step();
    chk("post_rst_grant", grant_id, 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $finish;
  end

endmodule
